// File: rtl/fb_spi_refresh.sv
// fb_spi_refresh: pushes one RGB565 frame from the frame buffer to a 4-wire SPI LCD
//   clk, rst         : system clock, synchronous active-high reset
//   start, abort     : frame request (ignored while busy), synchronous abort
//   busy, done       : frame in progress, one-cycle completion pulse
//   fb_rd_en/index   : frame buffer read request (combinational read port)
//   fb_rd_data       : RGB565 pixel, valid in the same cycle as the request
//   spi_sclk/mosi    : SPI mode 0 clock and data, MSB first
//   spi_cs_n, spi_dc : chip select (active low), command(0)/data(1) select
module fb_spi_refresh #(
    parameter int SCREEN_W = 240,
    parameter int SCREEN_H = 320,
    parameter int CLK_DIV  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        fb_rd_en,
    output logic [31:0] fb_rd_index,
    input  logic [15:0] fb_rd_data,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] PIX_HI = 3'd2;
    localparam logic [2:0] PIX_LO = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [31:0] PIX_LAST = 32'(SCREEN_W * SCREEN_H - 1);
    localparam logic [15:0] COL_END = 16'(SCREEN_W - 1);
    localparam logic [15:0] ROW_END = 16'(SCREEN_H - 1);

    logic [2:0]    r_state;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [3:0]    r_idx;
    logic [7:0]    r_sh;
    logic [7:0]    r_pix_lo;
    logic [31:0]   r_pix_cnt;
    logic [31:0]   r_rd_index;
    logic          r_sclk;
    logic          r_dc;
    logic          w_busy;
    logic          w_byte_end;
    logic          w_last_pix;
    logic          w_fetch;
    logic [31:0]   w_fetch_index;
    logic [8:0]    w_next;

    // {dc, byte} for each entry of the window setup sequence
    function automatic logic [8:0] setup_entry(input logic [3:0] i);
        case (i)
            4'd0:    setup_entry = {1'b0, 8'h2A};
            4'd3:    setup_entry = {1'b1, COL_END[15:8]};
            4'd4:    setup_entry = {1'b1, COL_END[7:0]};
            4'd5:    setup_entry = {1'b0, 8'h2B};
            4'd8:    setup_entry = {1'b1, ROW_END[15:8]};
            4'd9:    setup_entry = {1'b1, ROW_END[7:0]};
            4'd10:   setup_entry = {1'b0, 8'h2C};
            default: setup_entry = {1'b1, 8'h00};
        endcase
    endfunction

    always_comb begin
        w_busy        = r_state == SETUP || r_state == PIX_HI || r_state == PIX_LO;
        w_byte_end    = w_busy && r_sclk && r_div == DIV_LAST && r_bit == 3'd0;
        w_last_pix    = r_pix_cnt == PIX_LAST;
        // the read port is combinational, so the fetch is issued in the last
        // cycle of the preceding byte and captured on the edge that loads the pixel
        w_fetch       = w_byte_end && ((r_state == SETUP && r_idx == 4'd10) || (r_state == PIX_LO && !w_last_pix));
        w_fetch_index = (r_state == SETUP) ? 32'd0 : r_pix_cnt + 32'd1;
        w_next        = w_fetch ? {1'b1, fb_rd_data[15:8]} :
                        (r_state == PIX_HI) ? {1'b1, r_pix_lo} : setup_entry(r_idx + 4'd1);
    end

    assign busy        = w_busy;
    assign done        = r_state == FINISH;
    assign spi_cs_n    = !w_busy;
    assign spi_sclk    = r_sclk;
    assign spi_mosi    = r_sh[7];
    assign spi_dc      = r_dc;
    assign fb_rd_en    = w_fetch;
    assign fb_rd_index = w_fetch ? w_fetch_index : r_rd_index;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_bit      <= 3'd0;
            r_idx      <= 4'd0;
            r_sh       <= 8'h00;
            r_pix_lo   <= 8'h00;
            r_pix_cnt  <= 32'd0;
            r_rd_index <= 32'd0;
            r_sclk     <= 1'b0;
            r_dc       <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_state   <= SETUP;
                r_div     <= '0;
                r_bit     <= 3'd7;
                r_idx     <= 4'd0;
                r_pix_cnt <= 32'd0;
                r_sclk    <= 1'b0;
                {r_dc, r_sh} <= setup_entry(4'd0);
            end
        end else if (r_state == FINISH) begin
            r_state <= IDLE;
        end else if (r_div != DIV_LAST) begin
            r_div <= r_div + 1'b1;
        end else begin
            r_div  <= '0;
            r_sclk <= !r_sclk;
            if (r_sclk && r_bit != 3'd0) begin
                r_bit <= r_bit - 3'd1;
                r_sh  <= {r_sh[6:0], 1'b0};
            end else if (r_sclk) begin
                r_bit <= 3'd7;
                if (r_state == PIX_LO && w_last_pix) begin
                    r_state <= FINISH;
                    r_sh    <= 8'h00;
                    r_dc    <= 1'b0;
                end else begin
                    {r_dc, r_sh} <= w_next;
                    r_idx   <= (r_state == SETUP) ? r_idx + 4'd1 : r_idx;
                    r_state <= (r_state == PIX_HI) ? PIX_LO :
                               (r_state == SETUP && r_idx != 4'd10) ? SETUP : PIX_HI;
                    r_pix_cnt <= (r_state == PIX_LO) ? r_pix_cnt + 32'd1 : r_pix_cnt;
                    if (w_fetch) begin
                        r_pix_lo   <= fb_rd_data[7:0];
                        r_rd_index <= w_fetch_index;
                    end
                end
            end
        end
    end
endmodule
